// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction memory read port, decode handshake and control.
interface inst_fetch_if #(
  parameter int unsigned PC_W = 8
);
  localparam int unsigned INST_W = 8;

  logic              imem_en;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic [INST_W-1:0] inst_out;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              halt;
  logic [PC_W-1:0]   fetch_pc;

  modport master (
    output imem_en, imem_addr, inst_out, inst_pc, inst_valid, fetch_pc,
    input  imem_rdata, inst_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_en, imem_addr, inst_out, inst_pc, inst_valid, fetch_pc,
    output imem_rdata, inst_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, 1-cycle-latency imem requests, 2-entry FIFO toward decode,
// redirect with flush and halt.
module inst_fetch #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  inst_fetch_if.master bus
);
  localparam int unsigned INST_W = 8;
  localparam int unsigned CNT_W  = 2;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } entry_t;

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_q, state_d;
  entry_t           fifo_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             inflight_q;
  logic [PC_W-1:0]  inflight_pc_q;
  logic [PC_W-1:0]  fpc_q;

  logic             valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic             credit_ok;

  // Next state plus the per-cycle handshake/issue decisions
  always_comb begin
    state_d   = state_q;
    valid     = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    credit_ok = (count_q + CNT_W'(inflight_q)) < CNT_W'(2);

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN:  state_d = RUN;
    endcase

    valid = (count_q != '0) && !bus.redirect && !reset;
    pop   = valid && bus.inst_ready;
    push  = inflight_q && !bus.redirect && !reset;
    issue = (state_q == RUN) && !reset && !bus.redirect && !bus.halt && (credit_ok || pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      fpc_q         <= RESET_PC;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
    end else begin
      state_q <= state_d;
      if (bus.redirect) begin
        // Flush: drop buffered entries and the response arriving this cycle
        fpc_q      <= bus.redirect_pc;
        count_q    <= '0;
        inflight_q <= 1'b0;
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
      end else begin
        inflight_q <= issue;
        if (issue) begin
          fpc_q         <= fpc_q + PC_W'(1);
          inflight_pc_q <= fpc_q;
        end
        if (push) begin
          fifo_q[wr_ptr_q] <= '{inst: bus.imem_rdata, pc: inflight_pc_q};
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  assign bus.imem_en    = issue;
  assign bus.imem_addr  = fpc_q;
  assign bus.fetch_pc   = fpc_q;
  assign bus.inst_valid = valid;
  assign bus.inst_out   = fifo_q[rd_ptr_q].inst;
  assign bus.inst_pc    = fifo_q[rd_ptr_q].pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && count_q == CNT_W'(2)));
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model plus an in-order scoreboard of expected PCs.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];

  inst_fetch_if #(.PC_W(8)) bus ();

  inst_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, 1-cycle read latency; garbage when not read
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
    else             bus.imem_rdata <= 8'($urandom);
  end

  // Scoreboard: every accepted instruction must be the next expected PC with its memory byte
  always @(negedge clk) begin
    logic [7:0] exp_pc;
    #2;
    if (!reset && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc %h required no delivery", bus.inst_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (bus.inst_pc !== exp_pc || bus.inst_out !== mem[exp_pc]) begin
          errors++;
          $display("FAIL sb_deliver got pc %h inst %h required pc %h inst %h",
                   bus.inst_pc, bus.inst_out, exp_pc, mem[exp_pc]);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0; bus.inst_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
  endtask

  task automatic drain(input string name, input bit gap_check);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); bus.inst_ready = 1'b1; #1;
      if (gap_check) begin
        checks++;
        if (bus.inst_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s_gap got valid %b required 1", name, bus.inst_valid);
        end
      end
      #2;
      done = (exp_q.size() == 0);
    end
    @(negedge clk); bus.inst_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain got %0d left required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0; bus.inst_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({bus.imem_en, bus.inst_valid, bus.fetch_pc} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_hold got en %b valid %b fpc %h required 0 0 00",
               bus.imem_en, bus.inst_valid, bus.fetch_pc);
    end
    @(negedge clk); reset = 1'b0; exp_q.delete(); #1;
    checks++;
    if ({bus.imem_en, bus.inst_valid, bus.inst_out, bus.inst_pc, bus.fetch_pc} !== 26'h0) begin
      errors++;
      $display("FAIL reset_boot got en %b valid %b out %h pc %h fpc %h required all 0",
               bus.imem_en, bus.inst_valid, bus.inst_out, bus.inst_pc, bus.fetch_pc);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int p = 0; p < 8; p++) exp_q.push_back(8'(p));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); bus.inst_ready = 1'b1; #1;
      checks++;
      if ({bus.imem_en, bus.imem_addr} !== {1'b1, 8'(c - 1)}) begin
        errors++;
        $display("FAIL stream_issue got en %b addr %h required 1 %h", bus.imem_en, bus.imem_addr, 8'(c - 1));
      end
    end
    drain("stream", 1'b1);
  endtask

  task automatic test_backpressure();
    apply_reset();
    repeat (3) begin @(negedge clk); bus.inst_ready = 1'b0; end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); bus.inst_ready = 1'b0; #1;
      checks++;
      if ({bus.imem_en, bus.fetch_pc, bus.inst_valid, bus.inst_pc, bus.inst_out} !==
          {1'b0, 8'h02, 1'b1, 8'h00, mem[0]}) begin
        errors++;
        $display("FAIL bp_hold got en %b fpc %h valid %b pc %h out %h required 0 02 1 00 %h",
                 bus.imem_en, bus.fetch_pc, bus.inst_valid, bus.inst_pc, bus.inst_out, mem[0]);
      end
    end
    for (int p = 0; p < 4; p++) exp_q.push_back(8'(p));
    drain("bp", 1'b1);
  endtask

  task automatic test_redirect();
    apply_reset();
    repeat (2) begin @(negedge clk); bus.inst_ready = 1'b0; end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = (c == 0) ? 8'h80 : 8'h40; #1;
      checks++;
      if ({bus.inst_valid, bus.imem_en} !== 2'b00) begin
        errors++;
        $display("FAIL redir_flush got valid %b en %b required 0 0", bus.inst_valid, bus.imem_en);
      end
    end
    exp_q.delete();
    for (int p = 0; p < 4; p++) exp_q.push_back(8'(8'h40 + p));
    @(negedge clk); bus.redirect = 1'b0; #1;
    checks++;
    if ({bus.imem_en, bus.imem_addr, bus.fetch_pc} !== {1'b1, 8'h40, 8'h40}) begin
      errors++;
      $display("FAIL redir_target got en %b addr %h fpc %h required 1 40 40",
               bus.imem_en, bus.imem_addr, bus.fetch_pc);
    end
    drain("redir", 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    @(negedge clk); bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 8'hFE;
    for (int p = 0; p < 4; p++) exp_q.push_back(8'(8'hFE + p));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); bus.redirect = 1'b0; #1;
      checks++;
      if ({bus.imem_en, bus.imem_addr} !== {1'b1, 8'(8'hFE + c)}) begin
        errors++;
        $display("FAIL wrap_issue got en %b addr %h required 1 %h", bus.imem_en, bus.imem_addr, 8'(8'hFE + c));
      end
    end
    drain("wrap", 1'b0);
  endtask

  task automatic test_halt();
    apply_reset();
    for (int p = 0; p < 8; p++) exp_q.push_back(8'(p));
    repeat (3) begin @(negedge clk); bus.inst_ready = 1'b1; end
    for (int c = 4; c <= 7; c++) begin
      @(negedge clk); bus.halt = 1'b1; #1;
      checks++;
      if ({bus.imem_en, bus.fetch_pc} !== {1'b0, 8'h03}) begin
        errors++;
        $display("FAIL halt_block got en %b fpc %h required 0 03", bus.imem_en, bus.fetch_pc);
      end
      if (c == 5) begin
        checks++;
        if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 8'h02}) begin
          errors++;
          $display("FAIL halt_inflight got valid %b pc %h required 1 02", bus.inst_valid, bus.inst_pc);
        end
      end
    end
    @(negedge clk); bus.halt = 1'b0; #1;
    checks++;
    if ({bus.imem_en, bus.imem_addr} !== {1'b1, 8'h03}) begin
      errors++;
      $display("FAIL halt_resume got en %b addr %h required 1 03", bus.imem_en, bus.imem_addr);
    end
    drain("halt", 1'b0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (4) begin @(negedge clk); bus.inst_ready = 1'b0; end
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if (bus.imem_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_en got %b required 0", bus.imem_en);
    end
    @(negedge clk); reset = 1'b0; exp_q.delete(); #1;
    checks++;
    if ({bus.inst_valid, bus.fetch_pc, bus.imem_en} !== {1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_state got valid %b fpc %h en %b required 0 00 0",
               bus.inst_valid, bus.fetch_pc, bus.imem_en);
    end
    for (int p = 0; p < 3; p++) exp_q.push_back(8'(p));
    @(negedge clk); bus.inst_ready = 1'b1; #1;
    checks++;
    if ({bus.imem_en, bus.imem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL rstmid_issue got en %b addr %h required 1 00", bus.imem_en, bus.imem_addr);
    end
    drain("rstmid", 1'b0);
  endtask

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0; bus.inst_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a * 37 + 5);
    mem[0] = 8'h00; mem[1] = 8'h14; mem[2] = 8'h4B;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
